// File: rtl/boothr4_seq_if.sv
// Operand/product bus of the sequential radix-4 Booth multiplier.
// The master drives operands and start/stall; the slave returns product beats and status.
interface boothr4_seq_if #(
    parameter int WIDTH = 8
);
    logic             beginsig;
    logic             mode;
    logic             locksig;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             outvalid;
    logic             busy;
    logic             endsig;

    modport master (
        output beginsig, mode, locksig, inbus,
        input  outbus, outvalid, busy, endsig
    );

    modport slave (
        input  beginsig, mode, locksig, inbus,
        output outbus, outvalid, busy, endsig
    );
endinterface

// File: rtl/boothr4_seq.sv
// Sequential radix-4 Booth multiplier: loads Q then M, retires one recoded digit per clock,
// and returns the 2*WIDTH-bit product as two WIDTH-bit beats, low word first.
module boothr4_seq #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    boothr4_seq_if.slave bus
);
    // A carries four guard bits so that A +/- 2M never wraps, even for zero-extended operands.
    localparam int AW = WIDTH + 4;
    localparam int QW = WIDTH + 2;
    localparam int TW = AW + QW;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] K_SIGNED   = CW'(WIDTH / 2);
    localparam logic [CW-1:0] K_UNSIGNED = CW'(WIDTH / 2 + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Q = 3'd1,
        LOAD_M = 3'd2,
        CALC   = 3'd3,
        OUT_LO = 3'd4,
        OUT_HI = 3'd5
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [TW-1:0]    x_r, x_nxt_s;
    logic [AW-1:0]    m_r, m_nxt_s;
    logic             qm1_r, qm1_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             mode_r, mode_nxt_s;
    logic [AW-1:0]    a_s, addend_s, sum_s;
    logic [QW-1:0]    q_s;
    logic [2*WIDTH-1:0] p_s;
    logic [WIDTH-1:0] outbus_s, outbus_r;
    logic             outvalid_s, outvalid_r, busy_s, busy_r, endsig_s, endsig_r;

    function automatic logic [AW-1:0] ext_m(input logic [WIDTH-1:0] v, input logic sgn);
        return sgn ? {{(AW-WIDTH){v[WIDTH-1]}}, v} : {{(AW-WIDTH){1'b0}}, v};
    endfunction

    function automatic logic [QW-1:0] ext_q(input logic [WIDTH-1:0] v, input logic sgn);
        return sgn ? {{(QW-WIDTH){v[WIDTH-1]}}, v} : {{(QW-WIDTH){1'b0}}, v};
    endfunction

    function automatic logic [AW-1:0] booth_addend(input logic [2:0] trip, input logic [AW-1:0] m);
        logic [AW-1:0] r;
        case (trip)
            3'b001, 3'b010: r = m;
            3'b011:         r = m << 1;
            3'b100:         r = -(m << 1);
            3'b101, 3'b110: r = -m;
            default:        r = {AW{1'b0}};
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state decode; locksig freezes every state except IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (bus.beginsig)           state_nxt_s = LOAD_Q; else state_nxt_s = IDLE;
            LOAD_Q:  if (bus.locksig)            state_nxt_s = LOAD_Q; else state_nxt_s = LOAD_M;
            LOAD_M:  if (bus.locksig)            state_nxt_s = LOAD_M; else state_nxt_s = CALC;
            CALC:    if (!bus.locksig && cnt_r == CNT_ONE) state_nxt_s = OUT_LO; else state_nxt_s = CALC;
            OUT_LO:  if (bus.locksig)            state_nxt_s = OUT_LO; else state_nxt_s = OUT_HI;
            OUT_HI:  if (bus.locksig)            state_nxt_s = OUT_HI; else state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath next values: operand capture, Booth add and the 2-bit arithmetic shift of {A,Q,q(-1)}.
    always_comb begin
        x_nxt_s    = x_r;
        m_nxt_s    = m_r;
        qm1_nxt_s  = qm1_r;
        cnt_nxt_s  = cnt_r;
        mode_nxt_s = mode_r;
        a_s        = x_r[TW-1:QW];
        q_s        = x_r[QW-1:0];
        addend_s   = booth_addend({q_s[1:0], qm1_r}, m_r);
        sum_s      = a_s + addend_s;
        case (state_r)
            IDLE: begin
                if (bus.beginsig) mode_nxt_s = bus.mode;
                else              mode_nxt_s = mode_r;
            end
            LOAD_Q: begin
                if (!bus.locksig) x_nxt_s = {a_s, ext_q(bus.inbus, mode_r)};
                else              x_nxt_s = x_r;
            end
            LOAD_M: begin
                if (!bus.locksig) begin
                    m_nxt_s   = ext_m(bus.inbus, mode_r);
                    x_nxt_s   = {{AW{1'b0}}, q_s};
                    qm1_nxt_s = 1'b0;
                    cnt_nxt_s = mode_r ? K_SIGNED : K_UNSIGNED;
                end else begin
                    m_nxt_s   = m_r;
                end
            end
            CALC: begin
                if (!bus.locksig) begin
                    x_nxt_s   = {{2{sum_s[AW-1]}}, sum_s, q_s[QW-1:2]};
                    qm1_nxt_s = q_s[1];
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: x_nxt_s = x_r;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= {TW{1'b0}};
            m_r    <= {AW{1'b0}};
            qm1_r  <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            mode_r <= 1'b0;
        end else begin
            x_r    <= x_nxt_s;
            m_r    <= m_nxt_s;
            qm1_r  <= qm1_nxt_s;
            cnt_r  <= cnt_nxt_s;
            mode_r <= mode_nxt_s;
        end
    end

    // Output decode from the next state so that the registered beats line up with OUT_LO/OUT_HI.
    // Signed runs stop one digit early, leaving two unconsumed multiplier bits at the bottom of Q.
    always_comb begin
        if (mode_r) p_s = x_nxt_s[2*WIDTH+1:2];
        else        p_s = x_nxt_s[2*WIDTH-1:0];
        outbus_s   = {WIDTH{1'b0}};
        outvalid_s = 1'b0;
        endsig_s   = 1'b0;
        busy_s     = (state_nxt_s != IDLE);
        case (state_nxt_s)
            OUT_LO: begin
                outbus_s   = p_s[WIDTH-1:0];
                outvalid_s = 1'b1;
            end
            OUT_HI: begin
                outbus_s   = p_s[2*WIDTH-1:WIDTH];
                outvalid_s = 1'b1;
                endsig_s   = 1'b1;
            end
            default: begin
                outbus_s   = {WIDTH{1'b0}};
                outvalid_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            outbus_r   <= {WIDTH{1'b0}};
            outvalid_r <= 1'b0;
            busy_r     <= 1'b0;
            endsig_r   <= 1'b0;
        end else begin
            outbus_r   <= outbus_s;
            outvalid_r <= outvalid_s;
            busy_r     <= busy_s;
            endsig_r   <= endsig_s;
        end
    end

    assign bus.outbus   = outbus_r;
    assign bus.outvalid = outvalid_r;
    assign bus.busy     = busy_r;
    assign bus.endsig   = endsig_r;
endmodule

// File: tb/tb_boothr4_seq.sv
// Bench for boothr4_seq: a WIDTH=8 and a WIDTH=16 instance share one stimulus driver,
// expected beats go through a scoreboard queue and are checked as the DUT emits them.
module tb_boothr4_seq;
    logic        clk = 1'b0;
    logic        rst, beg, md, lk, sel;
    logic [15:0] din;
    logic        ov, endsig_m, busy_m;
    logic [15:0] ob;
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [15:0] sb[$];

    typedef struct {
        bit          w16;
        bit          sg;
        logic [15:0] q;
        logic [15:0] m;
        logic [31:0] p;
    } vec_t;
    vec_t tbl[9];

    boothr4_seq_if #(.WIDTH(8))  if8();
    boothr4_seq_if #(.WIDTH(16)) if16();

    assign if8.beginsig  = beg & ~sel;
    assign if16.beginsig = beg & sel;
    assign if8.mode      = md;
    assign if16.mode     = md;
    assign if8.locksig   = lk;
    assign if16.locksig  = lk;
    assign if8.inbus     = din[7:0];
    assign if16.inbus    = din;

    boothr4_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    boothr4_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    always #5 clk = ~clk;

    always_comb begin
        if (sel) begin
            ov = if16.outvalid; endsig_m = if16.endsig; busy_m = if16.busy; ob = if16.outbus;
        end else begin
            ov = if8.outvalid; endsig_m = if8.endsig; busy_m = if8.busy; ob = {8'h00, if8.outbus};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input bit w16, input bit sg, input logic [15:0] q, input logic [15:0] m);
        longint a, b, p;
        if (w16) begin
            a = sg ? longint'($signed(q)) : longint'({48'h0, q});
            b = sg ? longint'($signed(m)) : longint'({48'h0, m});
        end else begin
            a = sg ? longint'($signed(q[7:0])) : longint'({56'h0, q[7:0]});
            b = sg ? longint'($signed(m[7:0])) : longint'({56'h0, m[7:0]});
        end
        p = a * b;
        return w16 ? p[31:0] : {16'h0000, p[15:0]};
    endfunction

    // One full multiply, optionally stalled in CALC / OUT_LO or with a spurious beginsig in CALC.
    task automatic do_op(input bit w16, input bit sg, input logic [15:0] q, input logic [15:0] m,
                         input logic [31:0] p, input int cst, input int lst, input bit spur);
        int k;
        logic [15:0] exp_lo, exp_hi;
        k = w16 ? (sg ? 8 : 9) : (sg ? 4 : 5);
        sb.push_back(w16 ? p[15:0]  : {8'h00, p[7:0]});
        sb.push_back(w16 ? p[31:16] : {8'h00, p[15:8]});
        sel = w16; md = sg; beg = 1'b1; din = 16'h0000;
        tick(); n = 0;
        beg = 1'b0; din = q; md = ~sg;
        chk("busy_after_start", {31'd0, busy_m}, 32'd1);
        tick(); din = m;
        tick(); din = 16'hA5C3;
        tick();
        if (cst > 0) begin
            lk = 1'b1;
            repeat (cst) tick();
            lk = 1'b0;
        end
        if (spur) begin
            beg = 1'b1;
            tick();
            beg = 1'b0;
        end
        while (!ov && n < 200) tick();
        exp_lo = sb.pop_front();
        chk("lo_valid", {31'd0, ov}, 32'd1);
        chk("lo_edge", n, k + 2 + cst);
        chk("lo_word", {16'd0, ob}, {16'd0, exp_lo});
        chk("lo_endsig", {31'd0, endsig_m}, 32'd0);
        if (lst > 0) begin
            lk = 1'b1;
            repeat (lst) begin
                tick();
                chk("lo_hold", {14'd0, ov, endsig_m, ob}, {14'd0, 1'b1, 1'b0, exp_lo});
            end
            lk = 1'b0;
        end
        tick();
        exp_hi = sb.pop_front();
        chk("hi_word", {16'd0, ob}, {16'd0, exp_hi});
        chk("hi_endsig", {31'd0, endsig_m}, 32'd1);
        chk("hi_edge", n, k + 3 + cst + lst);
        tick();
        chk("idle_after", {14'd0, busy_m, ov, ob}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 16'h00D3, 16'h0045, 32'h0000F3DF};
        tbl[1] = '{1'b0, 1'b0, 16'h00D3, 16'h0045, 32'h000038DF};
        tbl[2] = '{1'b0, 1'b1, 16'h0080, 16'h0080, 32'h00004000};
        tbl[3] = '{1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01};
        tbl[4] = '{1'b0, 1'b1, 16'h00FF, 16'h0001, 32'h0000FFFF};
        tbl[5] = '{1'b0, 1'b1, 16'h005A, 16'h0000, 32'h00000000};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h00A7, 32'h00000000};
        tbl[7] = '{1'b1, 1'b1, 16'h8000, 16'h8000, 32'h40000000};
        tbl[8] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};

        rst = 1'b1; beg = 1'b0; md = 1'b0; lk = 1'b0; din = 16'h0000; sel = 1'b0;
        tick(); tick();
        chk("reset_w8", {22'd0, if8.busy, if8.outvalid, if8.endsig, if8.outbus[6:0]}, 32'd0);
        chk("reset_w16", {13'd0, if16.busy, if16.outvalid, if16.endsig, if16.outbus}, 32'd0);
        beg = 1'b1;
        tick();
        chk("rst_beats_begin", {31'd0, if8.busy}, 32'd0);
        rst = 1'b0; beg = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            do_op(tbl[i].w16, tbl[i].sg, tbl[i].q, tbl[i].m, tbl[i].p, 0, 0, 1'b0);

        do_op(1'b0, 1'b1, 16'h00D3, 16'h0045, 32'h0000F3DF, 3, 2, 1'b0);
        do_op(1'b0, 1'b1, 16'h00D3, 16'h0045, 32'h0000F3DF, 0, 0, 1'b1);

        // Reset during the second CALC cycle abandons the operation.
        sel = 1'b0; md = 1'b1; beg = 1'b1;
        tick(); beg = 1'b0; din = 16'h00D3;
        tick(); din = 16'h0045;
        tick();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_mid_outputs", {22'd0, if8.busy, if8.outvalid, if8.endsig, if8.outbus[6:0]}, 32'd0);
        chk("rst_mid_outbus7", {31'd0, if8.outbus[7]}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_no_endsig", {29'd0, busy_m, ov, endsig_m}, 32'd0);
        end
        do_op(1'b0, 1'b1, 16'h00D3, 16'h0045, 32'h0000F3DF, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [15:0] rq, rm;
            bit rw, rs;
            rw = ($urandom_range(0, 3) == 0);
            rs = $urandom_range(0, 1) == 1;
            rq = 16'($urandom);
            rm = 16'($urandom);
            if (!rw) begin
                rq[15:8] = 8'h00;
                rm[15:8] = 8'h00;
            end
            do_op(rw, rs, rq, rm, model(rw, rs, rq, rm), 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
